mem_access_unit: RTL and testbench

Memory-stage data access unit between the EX/MEM and MEM/WB pipeline registers. It takes the current memory-stage operation and performs at most one load or store on a valid/ready data bus. It stalls the pipeline until that access completes, then presents aligned, extended load data or a misalignment flag to the MEM/WB register. Non-memory operations pass through combinationally with zero latency.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// mem_access_unit_if : valid/ready data-memory bus between the memory stage
//                      and the data memory.
// Revision 1.0
// =============================================================================
interface mem_access_unit_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_wstrb;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// mem_access_unit : memory-stage load/store unit, stalls the pipeline until a
//                   single valid/ready bus access completes.
// Revision 1.0
// =============================================================================
module mem_access_unit (
   input  wire                clk,
   input  wire                reset,
   input  wire                in_valid_i,
   input  wire                in_load_i,
   input  wire                in_store_i,
   input  wire  [2:0]         in_funct3_i,
   input  wire  [31:0]        in_addr_i,
   input  wire  [31:0]        in_wdata_i,
   mem_access_unit_if.master  bus,
   output logic               stall_o,
   output logic               out_valid_o,
   output logic [31:0]        out_rdata_o,
   output logic               out_misaligned_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q;
   logic        req_valid_q;
   logic [31:0] req_addr_q;
   logic        req_we_q;
   logic [3:0]  req_wstrb_q;
   logic [31:0] req_wdata_q;
   logic [1:0]  offset_q;
   logic [2:0]  funct3_q;
   logic [31:0] rdata_q;

   logic        mem_op;
   logic        legal;
   logic        misaligned;
   logic        accept;
   logic [3:0]  wstrb_d;
   logic [31:0] wdata_d;
   logic [31:0] rsp_shifted;
   logic [31:0] rdata_d;

   assign mem_op = in_load_i | in_store_i;

   always_comb begin
      legal = 1'b0;
      if (in_store_i) begin
         legal = (in_funct3_i == 3'b000) || (in_funct3_i == 3'b001) || (in_funct3_i == 3'b010);
      end else begin
         legal = (in_funct3_i == 3'b000) || (in_funct3_i == 3'b001) || (in_funct3_i == 3'b010) ||
                 (in_funct3_i == 3'b100) || (in_funct3_i == 3'b101);
      end
   end

   assign misaligned = !legal ||
                       ((in_funct3_i[1:0] == 2'b01) && in_addr_i[0]) ||
                       ((in_funct3_i[1:0] == 2'b10) && (in_addr_i[1:0] != 2'b00));

   assign accept = (state_q == S_IDLE) && in_valid_i && mem_op && !misaligned;

   // Store data is replicated across lanes so the strobe alone selects the bytes.
   always_comb begin
      wstrb_d = 4'b0000;
      wdata_d = in_wdata_i;
      if (in_store_i) begin
         case (in_funct3_i[1:0])
            2'b00: begin
               wstrb_d = 4'b0001 << in_addr_i[1:0];
               wdata_d = {4{in_wdata_i[7:0]}};
            end
            2'b01: begin
               wstrb_d = 4'b0011 << in_addr_i[1:0];
               wdata_d = {2{in_wdata_i[15:0]}};
            end
            default: begin
               wstrb_d = 4'b1111;
               wdata_d = in_wdata_i;
            end
         endcase
      end
   end

   assign rsp_shifted = bus.mem_rsp_rdata >> {offset_q, 3'b000};

   always_comb begin
      rdata_d = rsp_shifted;
      case (funct3_q)
         3'b000:  rdata_d = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
         3'b001:  rdata_d = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
         3'b100:  rdata_d = {24'd0, rsp_shifted[7:0]};
         3'b101:  rdata_d = {16'd0, rsp_shifted[15:0]};
         default: rdata_d = rsp_shifted;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         req_valid_q <= 1'b0;
         req_addr_q  <= 32'd0;
         req_we_q    <= 1'b0;
         req_wstrb_q <= 4'd0;
         req_wdata_q <= 32'd0;
         offset_q    <= 2'd0;
         funct3_q    <= 3'd0;
         rdata_q     <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  req_addr_q  <= {in_addr_i[31:2], 2'b00};
                  req_we_q    <= in_store_i;
                  req_wstrb_q <= wstrb_d;
                  req_wdata_q <= wdata_d;
                  offset_q    <= in_addr_i[1:0];
                  funct3_q    <= in_funct3_i;
                  rdata_q     <= 32'd0;
                  req_valid_q <= 1'b1;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= req_we_q ? S_DONE : S_RESP;
               end
            end
            S_RESP: begin
               if (bus.mem_rsp_valid) begin
                  rdata_q <= rdata_d;
                  state_q <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_addr  = req_addr_q;
   assign bus.mem_req_we    = req_we_q;
   assign bus.mem_req_wstrb = req_wstrb_q;
   assign bus.mem_req_wdata = req_wdata_q;

   // Accepted memory ops report only from DONE, so the accept cycle shows no valid.
   assign stall_o          = (state_q == S_REQ) || (state_q == S_RESP) || accept;
   assign out_valid_o      = ((state_q == S_IDLE) && in_valid_i && !accept) || (state_q == S_DONE);
   assign out_misaligned_o = (state_q == S_IDLE) && in_valid_i && mem_op && misaligned;
   assign out_rdata_o      = (state_q == S_DONE) ? rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_mem_access_unit : randomized scoreboard bench with a byte-level memory
//                      reference model and a randomly stalling memory slave.
// Revision 1.0
// =============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_load, in_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        stall, out_valid, out_misaligned;
   logic [31:0] out_rdata;

   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit u_dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid_i       (in_valid),
      .in_load_i        (in_load),
      .in_store_i       (in_store),
      .in_funct3_i      (in_funct3),
      .in_addr_i        (in_addr),
      .in_wdata_i       (in_wdata),
      .bus              (bus.master),
      .stall_o          (stall),
      .out_valid_o      (out_valid),
      .out_rdata_o      (out_rdata),
      .out_misaligned_o (out_misaligned)
   );

   typedef struct packed {
      logic        mis;
      logic [31:0] rdata;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } req_t;

   exp_t        exp_q[$];
   req_t        req_q[$];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] act_mem [0:255];
   int          tests = 0;
   int          fails = 0;
   int          ready_wait = -1;
   int          rsp_wait = -1;
   int          n_hs = 0;
   req_t        last_req;
   logic [31:0] last_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Byte-addressed reference: loads gather bytes, stores scatter them.
   function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic mis, output logic [31:0] rd, output req_t rq);
      int          n;
      bit          legal;
      logic [31:0] v;
      n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      rd    = 32'd0;
      rq    = '0;
      v     = 32'd0;
      mis   = !legal || (n == 0);
      if (!mis) mis = (int'(a[1:0]) % n) != 0;
      if (mis) return;
      rq.addr = {a[31:2], 2'b00};
      rq.we   = st;
      for (int k = 0; k < n; k++) begin
         if (ld) v = v | (32'(ref_mem[a + k]) << (8 * k));
         else begin
            ref_mem[a + k] = wd[8*k +: 8];
            rq.strb[int'(a[1:0]) + k] = 1'b1;
         end
      end
      if (st) for (int l = 0; l < 4; l++) rq.wdata[8*l +: 8] = wd[8*(l % n) +: 8];
      if (ld) begin
         if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic issue(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int cyc);
      logic        mis;
      logic [31:0] rd;
      req_t        rq;
      exp_t        e;
      if (v) begin
         mis = 1'b0; rd = 32'd0; rq = '0;
         if (ld || st) model(ld, st, f3, a, wd, mis, rd, rq);
         e.mis = mis; e.rdata = rd;
         exp_q.push_back(e);
         if ((ld || st) && !mis) req_q.push_back(rq);
      end
      in_valid = v; in_load = ld; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!stall) break;
         if (cyc >= 60) begin
            tests++; fails++;
            $display("FAIL stall_timeout: got stall after %0d cycles expected release", cyc);
            break;
         end
      end
      chk("out_valid_final", {31'd0, out_valid}, {31'd0, v});
      @(posedge clk); #1;
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
   endtask

   // Output monitor: every out_valid pops one scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_misaligned", {31'd0, out_misaligned}, {31'd0, e.mis});
               chk("out_rdata", out_rdata, e.rdata);
               last_rdata = out_rdata;
            end
         end
      end
   end

   // Memory slave with programmable or random ready/response delays and rsp noise.
   initial begin
      bit          armed = 0;
      bit          pend = 0;
      int          rcnt = 0;
      int          scnt = 0;
      logic [31:0] pdata = 32'd0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
            armed = 0; pend = 0;
            continue;
         end
         bus.mem_rsp_valid = 1'b0;
         if (pend) begin
            if (scnt == 0) begin
               bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = pdata; pend = 0;
            end else scnt--;
         end else if ($urandom_range(0, 3) == 0) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = $urandom;
         end
         bus.mem_req_ready = 1'b0;
         if (bus.mem_req_valid) begin
            if (!armed) begin
               armed = 1;
               rcnt  = (ready_wait < 0) ? int'($urandom_range(0, 3)) : ready_wait;
            end
            if (rcnt == 0) begin
               req_t got;
               bus.mem_req_ready = 1'b1;
               armed = 0;
               n_hs++;
               got.addr = bus.mem_req_addr; got.we = bus.mem_req_we;
               got.strb = bus.mem_req_wstrb; got.wdata = bus.mem_req_wdata;
               last_req = got;
               if (req_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_request: got addr 0x%08h expected none", got.addr);
               end else begin
                  req_t exp;
                  exp = req_q.pop_front();
                  chk("req_addr", got.addr, exp.addr);
                  chk("req_we", {31'd0, got.we}, {31'd0, exp.we});
                  if (exp.we) begin
                     chk("req_wstrb", {28'd0, got.strb}, {28'd0, exp.strb});
                     chk("req_wdata", got.wdata, exp.wdata);
                  end
               end
               if (got.we) begin
                  for (int b = 0; b < 4; b++)
                     if (got.strb[b]) act_mem[got.addr[9:2]][8*b +: 8] = got.wdata[8*b +: 8];
               end else begin
                  pend  = 1;
                  pdata = act_mem[got.addr[9:2]];
                  scnt  = (rsp_wait < 0) ? int'($urandom_range(0, 3)) : rsp_wait;
               end
            end else rcnt--;
         end
      end
   end

   initial begin
      int          cyc;
      int          hs0;
      logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [2:0]  st_f3 [3] = '{3'd0, 3'd1, 3'd2};
      logic [31:0] x;

      for (int w = 0; w < 256; w++) begin
         x = $urandom;
         act_mem[w] = x;
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = x[8*b +: 8];
      end
      reset = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_req_addr", bus.mem_req_addr, 32'd0);
      chk("rst_req_we", {31'd0, bus.mem_req_we}, 32'd0);
      chk("rst_req_wstrb", {28'd0, bus.mem_req_wstrb}, 32'd0);
      chk("rst_req_wdata", bus.mem_req_wdata, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Reset mid-REQ abandons the request; the next LW starts fresh.
      ready_wait = 1000;
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40;
      @(negedge clk);
      chk("accept_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("req_valid_in_req", {31'd0, bus.mem_req_valid}, 32'd1);
      #1;
      in_valid = 1'b0; in_load = 1'b0; reset = 1'b0;
      #1;
      chk("midreq_rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("midreq_rst_stall", {31'd0, stall}, 32'd0);
      ready_wait = 0; rsp_wait = 0;
      @(negedge clk); @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      hs0 = n_hs;
      issue(1, 1, 0, 3'b010, 32'h40, 32'd0, cyc);
      chk("lw_after_reset_cycles", cyc, 32'd4);
      chk("lw_after_reset_hs", n_hs - hs0, 32'd1);

      issue(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, cyc);
      chk("sw_cycles", cyc, 32'd3);
      chk("sw_addr", last_req.addr, 32'h100);
      chk("sw_wstrb", {28'd0, last_req.strb}, 32'hF);
      chk("sw_we", {31'd0, last_req.we}, 32'd1);

      issue(1, 0, 1, 3'b000, 32'h103, 32'h000000A5, cyc);
      chk("sb_wstrb", {28'd0, last_req.strb}, 32'h8);
      chk("sb_wdata", last_req.wdata, 32'hA5A5A5A5);

      act_mem[32'h202 >> 2] = 32'h12F03456;
      ref_mem[32'h200] = 8'h56; ref_mem[32'h201] = 8'h34;
      ref_mem[32'h202] = 8'hF0; ref_mem[32'h203] = 8'h12;
      ready_wait = 2;
      issue(1, 1, 0, 3'b000, 32'h202, 32'd0, cyc);
      chk("lb_cycles", cyc, 32'd6);
      chk("lb_rdata", last_rdata, 32'hFFFFFFF0);
      issue(1, 1, 0, 3'b100, 32'h202, 32'd0, cyc);
      chk("lbu_cycles", cyc, 32'd6);
      chk("lbu_rdata", last_rdata, 32'h000000F0);

      ready_wait = 0;
      hs0 = n_hs;
      issue(1, 1, 0, 3'b010, 32'h201, 32'd0, cyc);
      chk("misaligned_cycles", cyc, 32'd1);
      chk("misaligned_no_bus", n_hs - hs0, 32'd0);
      issue(1, 0, 0, 3'b010, 32'h77, 32'h1234, cyc);
      chk("nonmem_cycles", cyc, 32'd1);
      chk("nonmem_no_bus", n_hs - hs0, 32'd0);

      ready_wait = -1; rsp_wait = -1;
      for (int i = 0; i < 300; i++) begin
         int          kind;
         logic        v, ld, st;
         logic [2:0]  f3;
         logic [31:0] a;
         kind = int'($urandom_range(0, 9));
         v  = (kind != 0);
         ld = (kind == 0) || (kind >= 3 && kind <= 6);
         st = (kind >= 7);
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else if (st) f3 = st_f3[$urandom_range(0, 2)];
         else f3 = ld_f3[$urandom_range(0, 4)];
         a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         issue(v, ld, st, f3, a, $urandom, cyc);
      end

      repeat (4) @(negedge clk);
      chk("exp_queue_drained", exp_q.size(), 32'd0);
      chk("req_queue_drained", req_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
